// File: rtl/mem_access_unit.sv
// Memory-stage data access controller: converts load/store controls into a
// req/ack transaction on a multi-cycle data memory and stalls the pipeline meanwhile.
//
// state | meaning
// IDLE  | evaluate the memory-stage instruction; issue request or flag misalignment
// WAIT  | request outstanding, counting edges until ack or timeout
// DONE  | result valid in ReadDataM, pipeline advances on this edge
module mem_access_unit #(
   parameter int TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MemReadM,
   input  logic        MemWriteM,
   input  logic [31:0] ALUOutM,
   input  logic [31:0] WriteDataM,
   output logic [31:0] ReadDataM,
   output logic        StallM,
   output logic        FaultM,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack
);

   localparam int CW = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic          access;
   logic          aligned;

   assign access  = MemReadM | MemWriteM;
   assign aligned = (ALUOutM[1:0] == 2'b00);
   assign StallM  = ((state == IDLE) && access && aligned) || (state == WAIT);

   // Falling edge: shares the edge with the pipeline segment registers.
   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         ReadDataM  <= '0;
         FaultM     <= 1'b0;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (access && aligned) begin
                  dmem_addr  <= ALUOutM;
                  dmem_wdata <= WriteDataM;
                  dmem_we    <= MemWriteM;
                  dmem_req   <= 1'b1;
                  cnt        <= '0;
                  FaultM     <= 1'b0;
                  state      <= WAIT;
               end else if (access) begin
                  FaultM    <= 1'b1;
                  ReadDataM <= '0;
               end else begin
                  FaultM <= 1'b0;
               end
            end
            WAIT: begin
               if (dmem_ack) begin
                  // Store (including load+store) returns zero; rdata is ignored.
                  ReadDataM <= dmem_we ? 32'h0 : dmem_rdata;
                  dmem_req  <= 1'b0;
                  dmem_we   <= 1'b0;
                  state     <= DONE;
               end else if (cnt == CNT_LAST) begin
                  dmem_req  <= 1'b0;
                  ReadDataM <= '0;
                  FaultM    <= 1'b1;
                  state     <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               FaultM <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: scenario tasks with a scoreboard queue
// of expected transaction results and a small responding memory model.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        MemReadM = 1'b0;
   logic        MemWriteM = 1'b0;
   logic [31:0] ALUOutM = '0;
   logic [31:0] WriteDataM = '0;
   logic [31:0] ReadDataM;
   logic        StallM;
   logic        FaultM;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata = '0;
   logic        dmem_ack = 1'b0;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] rd;
      logic        fault;
      int          stall;
      int          req;
   } exp_t;

   typedef struct {
      logic [31:0] rd;
      logic        fault;
      int          stall;
      int          req;
      bit          stable;
      bit          hung;
   } obs_t;

   exp_t sb[$];

   mem_access_unit #(.TIMEOUT(15)) dut (
      .clk        (clk),
      .rst        (rst),
      .MemReadM   (MemReadM),
      .MemWriteM  (MemWriteM),
      .ALUOutM    (ALUOutM),
      .WriteDataM (WriteDataM),
      .ReadDataM  (ReadDataM),
      .StallM     (StallM),
      .FaultM     (FaultM),
      .dmem_req   (dmem_req),
      .dmem_we    (dmem_we),
      .dmem_addr  (dmem_addr),
      .dmem_wdata (dmem_wdata),
      .dmem_rdata (dmem_rdata),
      .dmem_ack   (dmem_ack)
   );

   always #5 clk = ~clk;

   // Drives one access starting just after a falling edge, answers the request
   // after 'waits' extra WAIT cycles, and returns what was seen at the DONE cycle.
   task automatic run_access(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input int waits,
                             input logic [31:0] rdata, input bit ack_en, output obs_t o);
      int  k = 0;
      bit  done = 0;
      o = '{rd: 32'h0, fault: 1'b0, stall: 0, req: 0, stable: 1'b1, hung: 1'b0};
      MemReadM = rd; MemWriteM = wr; ALUOutM = addr; WriteDataM = wdata;
      for (int c = 0; c < 40 && !done; c++) begin
         @(posedge clk);
         if (StallM) o.stall++;
         else if (o.stall > 0) begin
            o.rd = ReadDataM; o.fault = FaultM; done = 1;
         end
         if (dmem_req) begin
            k++; o.req++;
            if (dmem_addr !== addr || dmem_wdata !== wdata || dmem_we !== wr) o.stable = 0;
         end
         dmem_ack   = dmem_req && ack_en && (k == waits + 1);
         dmem_rdata = dmem_ack ? rdata : 32'hDEADBEEF;
      end
      if (!done) o.hung = 1;
      @(negedge clk); #1;
      MemReadM = 0; MemWriteM = 0; ALUOutM = '0; WriteDataM = '0; dmem_ack = 0;
   endtask

   task automatic test_reset();
      #3;
      checks++;
      if ({dmem_req, dmem_we, FaultM, StallM} !== 4'b0000 || ReadDataM !== 32'h0 ||
          dmem_addr !== 32'h0 || dmem_wdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_hold: req=%b we=%b fault=%b stall=%b rd=%h addr=%h wdata=%h, want all 0",
                  dmem_req, dmem_we, FaultM, StallM, ReadDataM, dmem_addr, dmem_wdata);
      end
      #9 rst = 0;
      @(posedge clk);
      checks++;
      if ({dmem_req, dmem_we, FaultM, StallM} !== 4'b0000 || ReadDataM !== 32'h0) begin
         errors++;
         $display("FAIL reset_release: req=%b we=%b fault=%b stall=%b rd=%h, want all 0",
                  dmem_req, dmem_we, FaultM, StallM, ReadDataM);
      end
      @(negedge clk); #1;
   endtask

   task automatic test_load();
      obs_t o; exp_t e;
      sb.push_back('{rd: 32'hCAFEF00D, fault: 1'b0, stall: 2, req: 1});
      run_access(1'b1, 1'b0, 32'h100, 32'h0, 0, 32'hCAFEF00D, 1'b1, o);
      e = sb.pop_front();
      checks++;
      if (o.hung) begin errors++; $display("FAIL load_done: no DONE cycle seen, want one"); end
      checks++;
      if (o.stall !== e.stall || o.req !== e.req) begin
         errors++;
         $display("FAIL load_timing: stall=%0d req=%0d, want stall=%0d req=%0d", o.stall, o.req, e.stall, e.req);
      end
      checks++;
      if (o.rd !== e.rd || o.fault !== e.fault) begin
         errors++;
         $display("FAIL load_data: rd=%h fault=%b, want rd=%h fault=%b", o.rd, o.fault, e.rd, e.fault);
      end
      checks++;
      if (!o.stable) begin errors++; $display("FAIL load_stable: request fields changed, want stable"); end
   endtask

   task automatic test_store();
      obs_t o; exp_t e;
      sb.push_back('{rd: 32'h0, fault: 1'b0, stall: 5, req: 4});
      run_access(1'b0, 1'b1, 32'h204, 32'h12345678, 3, 32'h55555555, 1'b1, o);
      e = sb.pop_front();
      checks++;
      if (o.stall !== e.stall || o.req !== e.req || o.hung) begin
         errors++;
         $display("FAIL store_timing: stall=%0d req=%0d hung=%b, want stall=%0d req=%0d", o.stall, o.req, o.hung, e.stall, e.req);
      end
      checks++;
      if (o.rd !== e.rd || o.fault !== e.fault) begin
         errors++;
         $display("FAIL store_data: rd=%h fault=%b, want rd=%h fault=%b", o.rd, o.fault, e.rd, e.fault);
      end
      checks++;
      if (!o.stable) begin errors++; $display("FAIL store_stable: we/addr/wdata changed in WAIT, want stable"); end
   endtask

   task automatic test_back_to_back();
      obs_t o1, o2; exp_t e;
      sb.push_back('{rd: 32'hA, fault: 1'b0, stall: 2, req: 1});
      sb.push_back('{rd: 32'hB, fault: 1'b0, stall: 2, req: 1});
      run_access(1'b1, 1'b0, 32'h10, 32'h0, 0, 32'hA, 1'b1, o1);
      run_access(1'b1, 1'b0, 32'h14, 32'h0, 0, 32'hB, 1'b1, o2);
      e = sb.pop_front();
      checks++;
      if (o1.rd !== e.rd || o1.stall !== e.stall || o1.req !== e.req) begin
         errors++;
         $display("FAIL b2b_first: rd=%h stall=%0d req=%0d, want rd=%h stall=%0d req=%0d", o1.rd, o1.stall, o1.req, e.rd, e.stall, e.req);
      end
      e = sb.pop_front();
      checks++;
      if (o2.rd !== e.rd || o2.stall !== e.stall || o2.req !== e.req) begin
         errors++;
         $display("FAIL b2b_second: rd=%h stall=%0d req=%0d, want rd=%h stall=%0d req=%0d", o2.rd, o2.stall, o2.req, e.rd, e.stall, e.req);
      end
   endtask

   task automatic test_reset_mid_wait();
      bit seen = 0;
      MemReadM = 1; ALUOutM = 32'h300;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(posedge clk);
         if (dmem_req) seen = 1;
      end
      checks++;
      if (!seen) begin errors++; $display("FAIL rstwait_req: dmem_req=0, want 1 before reset"); end
      @(posedge clk);
      #2 rst = 1;
      #1;
      checks++;
      if (dmem_req !== 1'b0) begin
         errors++; $display("FAIL rstwait_async: dmem_req=%b, want 0 immediately", dmem_req);
      end
      MemReadM = 0; ALUOutM = '0;
      #1;
      checks++;
      if (StallM !== 1'b0 || FaultM !== 1'b0 || ReadDataM !== 32'h0 || dmem_addr !== 32'h0) begin
         errors++;
         $display("FAIL rstwait_values: stall=%b fault=%b rd=%h addr=%h, want 0", StallM, FaultM, ReadDataM, dmem_addr);
      end
      @(posedge clk); #1 rst = 0;
      dmem_ack = 1; dmem_rdata = 32'h99;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         dmem_ack = 0;
         checks++;
         if (dmem_req !== 1'b0 || StallM !== 1'b0 || FaultM !== 1'b0 || ReadDataM !== 32'h0) begin
            errors++;
            $display("FAIL late_ack: req=%b stall=%b fault=%b rd=%h, want 0", dmem_req, StallM, FaultM, ReadDataM);
         end
      end
      @(negedge clk); #1;
   endtask

   task automatic test_both_high();
      obs_t o1, o2; exp_t e;
      sb.push_back('{rd: 32'h5A5A5A5A, fault: 1'b0, stall: 3, req: 2});
      sb.push_back('{rd: 32'h0, fault: 1'b0, stall: 2, req: 1});
      run_access(1'b1, 1'b0, 32'h40, 32'h0, 1, 32'h5A5A5A5A, 1'b1, o1);
      run_access(1'b1, 1'b1, 32'h48, 32'hFEEDFACE, 0, 32'h77777777, 1'b1, o2);
      e = sb.pop_front();
      checks++;
      if (o1.rd !== e.rd || o1.stall !== e.stall || o1.req !== e.req) begin
         errors++;
         $display("FAIL wait1_load: rd=%h stall=%0d req=%0d, want rd=%h stall=%0d req=%0d", o1.rd, o1.stall, o1.req, e.rd, e.stall, e.req);
      end
      e = sb.pop_front();
      checks++;
      if (o2.rd !== e.rd || o2.stall !== e.stall || !o2.stable) begin
         errors++;
         $display("FAIL both_high: rd=%h stall=%0d stable=%b, want rd=%h stall=%0d stable=1", o2.rd, o2.stall, o2.stable, e.rd, e.stall);
      end
   endtask

   task automatic test_misaligned();
      obs_t o; exp_t e;
      logic s_stall, s_req, s_fault;
      logic [31:0] s_rd;
      run_access(1'b1, 1'b0, 32'h80, 32'h0, 0, 32'h77, 1'b1, o);
      checks++;
      if (o.rd !== 32'h77) begin errors++; $display("FAIL pre_load: rd=%h, want 00000077", o.rd); end
      sb.push_back('{rd: 32'h0, fault: 1'b1, stall: 0, req: 0});
      MemReadM = 1; ALUOutM = 32'h102;
      @(posedge clk);
      s_stall = StallM; s_req = dmem_req;
      @(negedge clk); #1;
      MemReadM = 0; ALUOutM = '0;
      @(posedge clk);
      s_fault = FaultM; s_rd = ReadDataM;
      e = sb.pop_front();
      checks++;
      if (s_stall !== 1'b0 || s_req !== 1'b0 || dmem_req !== 1'b0) begin
         errors++; $display("FAIL misalign_nostall: stall=%b req=%b, want 0", s_stall, s_req);
      end
      checks++;
      if (s_fault !== e.fault || s_rd !== e.rd) begin
         errors++; $display("FAIL misalign_fault: fault=%b rd=%h, want fault=%b rd=%h", s_fault, s_rd, e.fault, e.rd);
      end
      @(posedge clk);
      checks++;
      if (FaultM !== 1'b0) begin errors++; $display("FAIL misalign_clear: fault=%b, want 0", FaultM); end
      @(negedge clk); #1;
   endtask

   task automatic test_timeout();
      obs_t o; exp_t e;
      sb.push_back('{rd: 32'h0, fault: 1'b1, stall: 16, req: 15});
      run_access(1'b1, 1'b0, 32'h3C, 32'h0, 0, 32'h0, 1'b0, o);
      e = sb.pop_front();
      checks++;
      if (o.stall !== e.stall || o.req !== e.req || o.hung) begin
         errors++;
         $display("FAIL timeout_timing: stall=%0d req=%0d hung=%b, want stall=%0d req=%0d", o.stall, o.req, o.hung, e.stall, e.req);
      end
      checks++;
      if (o.fault !== e.fault || o.rd !== e.rd) begin
         errors++; $display("FAIL timeout_fault: fault=%b rd=%h, want fault=%b rd=%h", o.fault, o.rd, e.fault, e.rd);
      end
      @(posedge clk);
      checks++;
      if (FaultM !== 1'b0 || StallM !== 1'b0 || dmem_req !== 1'b0) begin
         errors++; $display("FAIL timeout_idle: fault=%b stall=%b req=%b, want 0", FaultM, StallM, dmem_req);
      end
   endtask

   initial begin
      test_reset();
      test_load();
      test_store();
      test_back_to_back();
      test_reset_mid_wait();
      test_both_high();
      test_misaligned();
      test_timeout();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
